// File: rtl/counter_bank_pkg.sv
// Shared definitions for the counter_bank block: per-channel next-state op
// encoding and the prescaler reset/reload constant.
package counter_bank_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } op_e;

    // Prescaler value after reset; zero makes the first tick land right after release.
    localparam int PRESCALE_RST = 0;

endpackage

// File: rtl/counter_bank_ch.sv
// One counter channel: op select, wrap/saturate arithmetic, and registered
// zero/compare/wrap event pulses.
module counter_bank_ch
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             enable,
    input  logic             clear,
    input  logic             up,
    input  logic             down,
    input  logic             auto_en,
    input  logic             saturate,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] cmp_value,
    output logic [WIDTH-1:0] count,
    output logic             eq_zero,
    output logic             eq_cmp,
    output logic             wrapped
);

    op_e              op;
    logic [WIDTH-1:0] next;
    logic             wrap_evt;
    logic             wrap_d;
    logic             zero_hist;
    logic             cmp_hist;
    logic             is_zero;
    logic             is_cmp;

    assign is_zero = (count == '0);
    assign is_cmp  = (count == cmp_value);

    always_comb begin
        op = OP_HOLD;
        if (clear)                   op = OP_CLEAR;
        else if (load)               op = OP_LOAD;
        else if (!enable)            op = OP_HOLD;
        else if (up && down)         op = OP_HOLD;
        else if (up)                 op = OP_INC;
        else if (down)               op = OP_DEC;
        else if (auto_en && tick)    op = OP_INC;
    end

    always_comb begin
        next     = count;
        wrap_evt = 1'b0;
        case (op)
            OP_CLEAR: next = '0;
            OP_LOAD:  next = load_value;
            OP_INC: begin
                if (count == '1) begin
                    next     = saturate ? count : '0;
                    wrap_evt = !saturate;
                end else begin
                    next = count + 1'b1;
                end
            end
            OP_DEC: begin
                if (count == '0) begin
                    next     = saturate ? count : '1;
                    wrap_evt = !saturate;
                end else begin
                    next = count - 1'b1;
                end
            end
            default: next = count;
        endcase
    end

    // wrapped is delayed one extra stage so it lines up with eq_zero after a wrap to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            wrap_d    <= 1'b0;
            wrapped   <= 1'b0;
            zero_hist <= 1'b1;
            cmp_hist  <= 1'b1;
            eq_zero   <= 1'b0;
            eq_cmp    <= 1'b0;
        end else begin
            count     <= next;
            wrap_d    <= wrap_evt;
            wrapped   <= wrap_d;
            zero_hist <= is_zero;
            cmp_hist  <= is_cmp;
            eq_zero   <= is_zero && !zero_hist;
            eq_cmp    <= is_cmp && !cmp_hist;
        end
    end

endmodule

// File: rtl/counter_bank.sv
// Bank of NUM_CH up/down counters sharing one programmable prescaler tick.
// Optional COUNTER_BANK_LOAD_EN adds per-channel parallel load ports.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PRESCALE_W-1:0]   prescale,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH-1:0]       ch_clear,
    input  logic [NUM_CH-1:0]       ch_up,
    input  logic [NUM_CH-1:0]       ch_down,
    input  logic [NUM_CH-1:0]       ch_auto,
    input  logic [NUM_CH-1:0]       ch_saturate,
    input  logic [NUM_CH*WIDTH-1:0] cmp_value,
`ifdef COUNTER_BANK_LOAD_EN
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_value,
`endif
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic                    tick,
    output logic [NUM_CH-1:0]       eq_zero,
    output logic [NUM_CH-1:0]       eq_cmp,
    output logic [NUM_CH-1:0]       wrapped
);

    logic [PRESCALE_W-1:0]   psc;
    logic [NUM_CH-1:0]       load_i;
    logic [NUM_CH*WIDTH-1:0] load_val_i;

`ifdef COUNTER_BANK_LOAD_EN
    assign load_i     = load;
    assign load_val_i = load_value;
`else
    assign load_i     = '0;
    assign load_val_i = '0;
`endif

    // A new prescale value is only sampled at reload, so the current period always completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc  <= PRESCALE_W'(PRESCALE_RST);
            tick <= 1'b0;
        end else if (psc == '0) begin
            psc  <= prescale;
            tick <= 1'b1;
        end else begin
            psc  <= psc - 1'b1;
            tick <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        counter_bank_ch #(.WIDTH(WIDTH)) u_ch (
            .clk        (clk),
            .rst        (reset),
            .tick       (tick),
            .enable     (ch_enable[i]),
            .clear      (ch_clear[i]),
            .up         (ch_up[i]),
            .down       (ch_down[i]),
            .auto_en    (ch_auto[i]),
            .saturate   (ch_saturate[i]),
            .load       (load_i[i]),
            .load_value (load_val_i[i*WIDTH +: WIDTH]),
            .cmp_value  (cmp_value[i*WIDTH +: WIDTH]),
            .count      (count[i*WIDTH +: WIDTH]),
            .eq_zero    (eq_zero[i]),
            .eq_cmp     (eq_cmp[i]),
            .wrapped    (wrapped[i])
        );
    end

endmodule

// File: tb/tb_counter_bank.sv
// Directed self-checking bench for counter_bank (default parameters).
module tb_counter_bank;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int PW     = 24;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [PW-1:0]           prescale;
    logic [NUM_CH-1:0]       ch_enable, ch_clear, ch_up, ch_down, ch_auto, ch_saturate;
    logic [NUM_CH*WIDTH-1:0] cmp_value;
    logic [NUM_CH*WIDTH-1:0] count;
    logic                    tick;
    logic [NUM_CH-1:0]       eq_zero, eq_cmp, wrapped;
`ifdef COUNTER_BANK_LOAD_EN
    logic [NUM_CH-1:0]       load = '0;
    logic [NUM_CH*WIDTH-1:0] load_value = '0;
`endif

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .prescale    (prescale),
        .ch_enable   (ch_enable),
        .ch_clear    (ch_clear),
        .ch_up       (ch_up),
        .ch_down     (ch_down),
        .ch_auto     (ch_auto),
        .ch_saturate (ch_saturate),
        .cmp_value   (cmp_value),
`ifdef COUNTER_BANK_LOAD_EN
        .load        (load),
        .load_value  (load_value),
`endif
        .count       (count),
        .tick        (tick),
        .eq_zero     (eq_zero),
        .eq_cmp      (eq_cmp),
        .wrapped     (wrapped)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_up(input int ch);
        ch_up[ch] = 1'b1; step(); ch_up[ch] = 1'b0;
    endtask

    task automatic pulse_down(input int ch);
        ch_down[ch] = 1'b1; step(); ch_down[ch] = 1'b0;
    endtask

    task automatic pulse_clear(input int ch);
        ch_clear[ch] = 1'b1; step(); ch_clear[ch] = 1'b0;
    endtask

    task automatic test_reset();
        int exp_cnt;
        logic exp_tick;
        reset = 1'b1; prescale = 24'd3;
        ch_enable = '0; ch_clear = '0; ch_up = '0; ch_down = '0;
        ch_auto = '0; ch_saturate = '0; cmp_value = '0;
        step(); step();
        vec++; if (count !== '0 || tick !== 1'b0 || eq_zero !== '0 || eq_cmp !== '0 || wrapped !== '0) begin
            miss++; $display("FAIL reset_state count=%h tick=%b ez=%b ec=%b wr=%b (want all 0)", count, tick, eq_zero, eq_cmp, wrapped);
        end
        ch_enable = 4'b1111; ch_auto[0] = 1'b1;
        reset = 1'b0;
        exp_cnt = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            exp_tick = (n % 4 == 1);
            vec++; if (tick !== exp_tick) begin
                miss++; $display("FAIL auto_tick cyc%0d got=%b want=%b", n, tick, exp_tick);
            end
            vec++; if (count[7:0] !== 8'(exp_cnt)) begin
                miss++; $display("FAIL auto_count cyc%0d got=%h want=%h", n, count[7:0], 8'(exp_cnt));
            end
            vec++; if (eq_zero !== '0) begin
                miss++; $display("FAIL reset_eq_zero cyc%0d got=%b want=0", n, eq_zero);
            end
            if (exp_tick) exp_cnt++;
        end
        ch_auto[0] = 1'b0;
    endtask

    task automatic test_wrap();
        pulse_clear(0);
        step();
        pulse_down(0);
        vec++; if (count[7:0] !== 8'hFF) begin miss++; $display("FAIL wrap_down got=%h want=ff", count[7:0]); end
        step();
        vec++; if (wrapped[0] !== 1'b1) begin miss++; $display("FAIL wrap_down_pulse got=%b want=1", wrapped[0]); end
        pulse_down(0);
        vec++; if (count[7:0] !== 8'hFE) begin miss++; $display("FAIL wrap_fe got=%h want=fe", count[7:0]); end
        step(); step();
        pulse_up(0);
        vec++; if (count[7:0] !== 8'hFF) begin miss++; $display("FAIL wrap_ff got=%h want=ff", count[7:0]); end
        pulse_up(0);
        vec++; if (count[7:0] !== 8'h00 || wrapped[0] !== 1'b0 || eq_zero[0] !== 1'b0) begin
            miss++; $display("FAIL wrap_00 count=%h wr=%b ez=%b want 00/0/0", count[7:0], wrapped[0], eq_zero[0]);
        end
        step();
        vec++; if (wrapped[0] !== 1'b1 || eq_zero[0] !== 1'b1) begin
            miss++; $display("FAIL wrap_pulse wr=%b ez=%b want 1/1", wrapped[0], eq_zero[0]);
        end
        step();
        vec++; if (wrapped[0] !== 1'b0 || eq_zero[0] !== 1'b0) begin
            miss++; $display("FAIL wrap_pulse_end wr=%b ez=%b want 0/0", wrapped[0], eq_zero[0]);
        end
    endtask

    task automatic test_saturate();
        ch_saturate[0] = 1'b1;
        pulse_down(0);
        vec++; if (count[7:0] !== 8'h00) begin miss++; $display("FAIL sat_low got=%h want=00", count[7:0]); end
        step();
        vec++; if (wrapped[0] !== 1'b0 || eq_zero[0] !== 1'b0) begin
            miss++; $display("FAIL sat_low_pulse wr=%b ez=%b want 0/0", wrapped[0], eq_zero[0]);
        end
        ch_saturate[0] = 1'b0;
        pulse_down(0);
        step();
        vec++; if (count[7:0] !== 8'hFF || wrapped[0] !== 1'b1) begin
            miss++; $display("FAIL mode_change count=%h wr=%b want ff/1", count[7:0], wrapped[0]);
        end
        ch_saturate[0] = 1'b1;
        pulse_up(0);
        vec++; if (count[7:0] !== 8'hFF) begin miss++; $display("FAIL sat_high got=%h want=ff", count[7:0]); end
        step();
        vec++; if (wrapped[0] !== 1'b0) begin miss++; $display("FAIL sat_high_pulse got=%b want=0", wrapped[0]); end
        ch_saturate[0] = 1'b0;
    endtask

    task automatic test_compare();
        cmp_value[7:0] = 8'h05;
        pulse_clear(0);
        step(); step();
        for (int i = 1; i <= 5; i++) begin
            pulse_up(0);
            vec++; if (count[7:0] !== 8'(i) || eq_cmp[0] !== 1'b0) begin
                miss++; $display("FAIL cmp_ramp%0d count=%h ec=%b want %h/0", i, count[7:0], eq_cmp[0], 8'(i));
            end
        end
        step();
        vec++; if (eq_cmp[0] !== 1'b1) begin miss++; $display("FAIL cmp_hit got=%b want=1", eq_cmp[0]); end
        step();
        vec++; if (eq_cmp[0] !== 1'b0) begin miss++; $display("FAIL cmp_hold got=%b want=0", eq_cmp[0]); end
        pulse_up(0);
        pulse_down(0);
        vec++; if (count[7:0] !== 8'h05 || eq_cmp[0] !== 1'b0) begin
            miss++; $display("FAIL cmp_back count=%h ec=%b want 05/0", count[7:0], eq_cmp[0]);
        end
        step();
        vec++; if (eq_cmp[0] !== 1'b1) begin miss++; $display("FAIL cmp_rearm got=%b want=1", eq_cmp[0]); end
        cmp_value[7:0] = 8'h09;
        step();
        vec++; if (eq_cmp[0] !== 1'b0) begin miss++; $display("FAIL cmp_change_off got=%b want=0", eq_cmp[0]); end
        cmp_value[7:0] = 8'h05;
        step();
        vec++; if (eq_cmp[0] !== 1'b1) begin miss++; $display("FAIL cmp_change_on got=%b want=1", eq_cmp[0]); end
    endtask

    task automatic test_cancel_clear();
        prescale = 24'd0;
        repeat (5) step();
        vec++; if (tick !== 1'b1) begin miss++; $display("FAIL tick_every_cycle got=%b want=1", tick); end
        ch_auto[0] = 1'b1; ch_up[0] = 1'b1; ch_down[0] = 1'b1;
        step();
        ch_auto[0] = 1'b0; ch_up[0] = 1'b0; ch_down[0] = 1'b0;
        vec++; if (count[7:0] !== 8'h05) begin miss++; $display("FAIL cancel got=%h want=05", count[7:0]); end
        ch_auto[0] = 1'b1; ch_up[0] = 1'b1;
        step();
        ch_auto[0] = 1'b0; ch_up[0] = 1'b0;
        vec++; if (count[7:0] !== 8'h06) begin miss++; $display("FAIL auto_dropped got=%h want=06", count[7:0]); end
        pulse_up(0);
        ch_enable[0] = 1'b0;
        pulse_up(0);
        vec++; if (count[7:0] !== 8'h07) begin miss++; $display("FAIL disabled_hold got=%h want=07", count[7:0]); end
        pulse_clear(0);
        vec++; if (count[7:0] !== 8'h00) begin miss++; $display("FAIL clear_disabled got=%h want=00", count[7:0]); end
        step();
        vec++; if (eq_zero[0] !== 1'b1) begin miss++; $display("FAIL clear_eq_zero got=%b want=1", eq_zero[0]); end
        ch_enable[0] = 1'b1;
        pulse_up(1);
        vec++; if (count[15:8] !== 8'h01 || count[7:0] !== 8'h00) begin
            miss++; $display("FAIL ch_independent ch1=%h ch0=%h want 01/00", count[15:8], count[7:0]);
        end
    endtask

    task automatic test_async_reset();
        ch_auto[0] = 1'b1;
        repeat (58) step();
        ch_auto[0] = 1'b0;
        vec++; if (count[7:0] !== 8'h3A) begin miss++; $display("FAIL pre_reset_count got=%h want=3a", count[7:0]); end
        prescale = 24'd9;
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        vec++; if (count !== '0 || tick !== 1'b0 || eq_zero !== '0 || eq_cmp !== '0 || wrapped !== '0) begin
            miss++; $display("FAIL async_reset count=%h tick=%b ez=%b ec=%b wr=%b (want all 0)", count, tick, eq_zero, eq_cmp, wrapped);
        end
        step();
        reset = 1'b0; ch_auto[0] = 1'b1;
        step();
        vec++; if (tick !== 1'b1 || count[7:0] !== 8'h00 || eq_zero !== '0) begin
            miss++; $display("FAIL resume_tick tick=%b count=%h ez=%b want 1/00/0", tick, count[7:0], eq_zero);
        end
        step();
        vec++; if (tick !== 1'b0 || count[7:0] !== 8'h01) begin
            miss++; $display("FAIL resume_count tick=%b count=%h want 0/01", tick, count[7:0]);
        end
        ch_auto[0] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_compare();
        test_cancel_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/counter_bank.md
Name: counter_bank

Overview:
- Parametrised bank of NUM_CH independent up/down counters, each WIDTH bits wide.
- All channels are clocked by one clock and advanced by one shared programmable prescaler tick.
- Every channel has clear, enable, manual step, autocount and wrap/saturate controls, plus zero/compare/wrap event pulses.
- Sits between host endpoint wires/triggers (control in, counts and trigger pulses out) and board LEDs/logic; generalises the two fixed 8-bit sample counters.

Parameters:
NUM_CH, 4, number of counter channels (1..16)
WIDTH, 8, counter width in bits (2..32)
PRESCALE_W, 24, prescaler reload width

Ports:
clk  in  1  single clock for all logic
reset  in  1  asynchronous, active-high; clears all state
prescale  in  PRESCALE_W  prescaler reload value; tick period = prescale+1 clk cycles
ch_enable  in  NUM_CH  level; 0 freezes the channel (clear still acts)
ch_clear  in  NUM_CH  level; synchronous clear to 0
ch_up  in  NUM_CH  one-cycle trigger; +1
ch_down  in  NUM_CH  one-cycle trigger; -1
ch_auto  in  NUM_CH  level; +1 on each prescaler tick
ch_saturate  in  NUM_CH  level; 1 = saturate at 0/max, 0 = wrap
cmp_value  in  NUM_CH*WIDTH  per-channel compare value; channel i at [i*WIDTH +: WIDTH]
count  out  NUM_CH*WIDTH  current counts, same packing
tick  out  1  one-cycle prescaler tick pulse
eq_zero  out  NUM_CH  one-cycle pulse when count becomes 0
eq_cmp  out  NUM_CH  one-cycle pulse when count becomes equal to cmp_value
wrapped  out  NUM_CH  one-cycle pulse on an over/underflow wrap

Behaviour:
- Reset (asynchronous, active-high): prescaler = prescale-independent 0, count = 0, tick = 0, eq_zero = 0, eq_cmp = 0, wrapped = 0, edge-history registers = 1.
  - Since count = 0 at reset, no eq_zero pulse occurs on reset release.
- Prescaler: down-counter.
  - At 0: reload from prescale and assert tick for exactly one cycle; otherwise decrement.
  - prescale = 0 → tick every cycle.
  - A prescale change takes effect at the next reload.
- Per-channel next-state priority, evaluated every cycle:
  1. ch_clear → 0, regardless of ch_enable.
  2. ch_enable = 0 → hold.
  3. ch_up and ch_down both set → hold (cancel).
  4. ch_up → +1.
  5. ch_down → -1.
  6. ch_auto and tick → +1.
  7. Otherwise hold.
  - Manual up/down in the same cycle as an auto tick: the auto increment is dropped, not accumulated.
- Arithmetic is modulo 2^WIDTH.
  - Wrap mode: max+1 → 0 and 0-1 → max; wrapped pulses in the cycle after the wrapping update.
  - Saturate mode: max+1 → max and 0-1 → 0, with no wrapped pulse.
  - Clear never produces a wrapped pulse.
- count is registered; the update is visible one cycle after the qualifying input.
- eq_zero / eq_cmp are registered edge detectors:
  - Pulse one cycle after count first equals the target.
  - They do not re-pulse while the count stays equal.
  - They re-arm once the count differs.
  - If cmp_value changes to equal the current count, eq_cmp pulses once.
  - eq_zero pulses after a clear from a nonzero count.
- Mode change (ch_saturate) mid-count: takes effect on the next update; no change to the current count.

Optional Feature:
COUNTER_BANK_LOAD_EN
- Defined: adds ports load (in, NUM_CH, one-cycle trigger) and load_value (in, NUM_CH*WIDTH).
  - load has priority directly below ch_clear and ignores ch_enable.
  - The loaded value is visible next cycle and may raise eq_zero/eq_cmp.
  - A load never raises wrapped.
- Undefined: neither port exists and priority is as listed above.

Decomposition:
- Package counter_bank_pkg:
  - op encoding for the per-channel next-state select: OP_HOLD, OP_CLEAR, OP_LOAD, OP_INC, OP_DEC.
  - Helper constant for the default prescale reload.
- Sub-module counter_bank_ch, one counter channel:
  - Contains the op select, saturate/wrap arithmetic, and eq/wrap edge detectors.
  - Instantiated NUM_CH times via generate.
- Prescaler and packing logic stay in the top level.

Test Plan:
- Reset release, prescale=3, ch_auto=1, ch_enable=1 on ch0 → tick every 4 cycles; count0 = 1, 2, 3 after the 1st, 2nd and 3rd ticks; eq_zero silent after reset.
- WIDTH=8, wrap mode, count=8'hFE, two ch_up pulses → FF then 00; wrapped pulses once one cycle after 00 appears; eq_zero pulses in the same cycle.
- Saturate mode, count=8'h00, ch_down → stays 00, no wrapped pulse, no eq_zero pulse; count=FF, ch_up → stays FF.
- cmp_value=8'h05, ch_up ×5 → eq_cmp pulses exactly once, one cycle after count=05; ch_up, then ch_down back to 05 → pulses again.
- ch_up and ch_down asserted in the same cycle together with a tick and ch_auto=1 → count unchanged; ch_clear with ch_enable=0 and count=7 → 0, then eq_zero pulse.
- Reset asserted asynchronously mid-count (count=0x3A, prescaler mid-way) → all outputs 0 immediately without a clock edge; counting resumes from 0 after release.
